// File: rtl/lc3_int_ctrl.sv
// lc3_int_ctrl: multi-channel interrupt controller for the LC-3 datapath.
// Per-channel pending/enable/priority/vector state, priority arbitration against PSR, registered request to control.
module lc3_int_ctrl #(
    parameter int                NUM_CH    = 8,
    parameter int                PRIO_W    = 3,
    parameter int                VEC_W     = 8,
    parameter logic [7:0]        VEC_BASE  = 8'h01,
    parameter logic [NUM_CH-1:0] EDGE_MASK = {NUM_CH{1'b1}},
    localparam int               ID_W      = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] irq,
    input  logic [PRIO_W-1:0] cur_prio,
    input  logic              cfg_we,
    input  logic [ID_W-1:0]   cfg_sel,
    input  logic              cfg_en,
    input  logic [PRIO_W-1:0] cfg_prio,
    input  logic [VEC_W-1:0]  cfg_vec,
    input  logic              int_ack,
    output logic              int_req,
    output logic [ID_W-1:0]   int_id,
    output logic [PRIO_W-1:0] int_prio,
    output logic [15:0]       int_vector,
    output logic [NUM_CH-1:0] pending
);

    if (VEC_W > 8) begin : g_vec_w_check
        $error("lc3_int_ctrl: VEC_W must not exceed 8");
    end
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_num_ch_check
        $error("lc3_int_ctrl: NUM_CH must be within 2..16");
    end

    logic [NUM_CH-1:0] en;
    logic [PRIO_W-1:0] prio [NUM_CH];
    logic [VEC_W-1:0]  vec  [NUM_CH];
    logic [NUM_CH-1:0] irq_d;
    logic [NUM_CH-1:0] pending_next;
    logic [NUM_CH-1:0] cand_p0;
    logic              win_hit_p0;
    logic [ID_W-1:0]   win_id_p0;
    logic [PRIO_W-1:0] win_prio_p0;
    logic [VEC_W-1:0]  win_vec_p0;
    logic [7:0]        win_vec8_p0;
    logic              vld_p0;
    logic              ack_accept;

    // Only a presented request can be acknowledged; the bubble after an ack blocks a second clear.
    assign ack_accept = int_ack & int_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                prio[i] <= '0;
                vec[i]  <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_sel == ID_W'(i)) begin
                    en[i]   <= cfg_en;
                    prio[i] <= cfg_prio;
                    vec[i]  <= cfg_vec;
                end
            end
        end
    end

    // Capture stage: new edge beats a same-cycle clearing ack.
    always_comb begin
        pending_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (EDGE_MASK[i]) begin
                pending_next[i] = (irq[i] & ~irq_d[i]) |
                                  (pending[i] & ~(ack_accept && (int_id == ID_W'(i))));
            end else begin
                pending_next[i] = irq[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_d   <= '0;
            pending <= '0;
        end else begin
            irq_d   <= irq;
            pending <= pending_next;
        end
    end

    // Arbitration stage: strict greater-than keeps the lowest index on priority ties.
    always_comb begin
        cand_p0     = pending & en;
        win_hit_p0  = 1'b0;
        win_id_p0   = '0;
        win_prio_p0 = '0;
        win_vec_p0  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cand_p0[i] && (!win_hit_p0 || (prio[i] > win_prio_p0))) begin
                win_hit_p0  = 1'b1;
                win_id_p0   = ID_W'(i);
                win_prio_p0 = prio[i];
                win_vec_p0  = vec[i];
            end
        end
    end

    assign vld_p0      = win_hit_p0 && (win_prio_p0 > cur_prio);
    assign win_vec8_p0 = 8'(win_vec_p0);

    // Output stage: fields hold when nothing qualifies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_req    <= 1'b0;
            int_id     <= '0;
            int_prio   <= '0;
            int_vector <= 16'h0000;
        end else begin
            int_req <= vld_p0 & ~ack_accept;
            if (vld_p0) begin
                int_id     <= win_id_p0;
                int_prio   <= win_prio_p0;
                int_vector <= {VEC_BASE, win_vec8_p0};
            end
        end
    end

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Scoreboard bench for lc3_int_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_lc3_int_ctrl;

    localparam logic [7:0] EDGE = 8'hFE;

    typedef struct packed {
        logic        req;
        logic [2:0]  id;
        logic [2:0]  prio;
        logic [15:0] vec;
        logic [7:0]  pend;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  irq = '0;
    logic [2:0]  cur_prio = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_sel = '0;
    logic        cfg_en = 1'b0;
    logic [2:0]  cfg_prio = '0;
    logic [7:0]  cfg_vec = '0;
    logic        int_ack = 1'b0;
    logic        int_req;
    logic [2:0]  int_id;
    logic [2:0]  int_prio;
    logic [15:0] int_vector;
    logic [7:0]  pending;

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    // Reference state, expressed as plain per-channel records.
    bit   m_pend [8];
    bit   m_en   [8];
    bit   m_irqd [8];
    int   m_prio [8];
    int   m_vec  [8];
    exp_t m_out = '0;

    lc3_int_ctrl #(.NUM_CH(8), .PRIO_W(3), .VEC_W(8), .VEC_BASE(8'h01), .EDGE_MASK(EDGE)) dut (
        .clk(clk), .rst(rst), .irq(irq), .cur_prio(cur_prio),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_en(cfg_en), .cfg_prio(cfg_prio), .cfg_vec(cfg_vec),
        .int_ack(int_ack), .int_req(int_req), .int_id(int_id), .int_prio(int_prio),
        .int_vector(int_vector), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predicts the registered outputs after the coming rising edge from the current inputs.
    task automatic model_step();
        int  best, best_key, key;
        bit  ack_ok, qual;
        bit  np [8];
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0; m_en[i] = 0; m_irqd[i] = 0; m_prio[i] = 0; m_vec[i] = 0;
            end
            m_out = '0;
        end else begin
            ack_ok   = int_ack && m_out.req;
            best     = -1;
            best_key = -1;
            for (int i = 0; i < 8; i++) begin
                if (m_pend[i] && m_en[i]) begin
                    key = m_prio[i] * 8 + (7 - i);
                    if (key > best_key) begin
                        best_key = key;
                        best     = i;
                    end
                end
            end
            qual = (best >= 0) && (m_prio[best] > int'(cur_prio));
            for (int i = 0; i < 8; i++) begin
                if (EDGE[i])
                    np[i] = (irq[i] && !m_irqd[i]) || (m_pend[i] && !(ack_ok && int'(m_out.id) == i));
                else
                    np[i] = irq[i];
            end
            m_out.req = qual && !ack_ok;
            if (qual) begin
                m_out.id   = 3'(best);
                m_out.prio = 3'(m_prio[best]);
                m_out.vec  = 16'h0100 + 16'(m_vec[best]);
            end
            if (cfg_we) begin
                m_en[cfg_sel]   = cfg_en;
                m_prio[cfg_sel] = int'(cfg_prio);
                m_vec[cfg_sel]  = int'(cfg_vec);
            end
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = np[i];
                m_irqd[i] = irq[i];
            end
        end
        for (int i = 0; i < 8; i++) m_out.pend[i] = m_pend[i];
        q.push_back(m_out);
    endtask

    always @(negedge clk) begin
        #2;
        model_step();
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_int_req",    32'(int_req),    32'(e.req));
            chk("sb_int_id",     32'(int_id),     32'(e.id));
            chk("sb_int_prio",   32'(int_prio),   32'(e.prio));
            chk("sb_int_vector", 32'(int_vector), 32'(e.vec));
            chk("sb_pending",    32'(pending),    32'(e.pend));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic [7:0] i, input logic [2:0] cp, input logic a);
        @(negedge clk);
        irq = i; cur_prio = cp; int_ack = a; cfg_we = 1'b0;
    endtask

    task automatic cfg(input int ch, input logic e, input logic [2:0] p, input logic [7:0] v);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 3'(ch); cfg_en = e; cfg_prio = p; cfg_vec = v; int_ack = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Single edge channel: two-cycle latency, ack clears.
        cfg(3, 1'b1, 3'd4, 8'h80);
        cyc(8'h00, 3'd2, 1'b0);
        cyc(8'h08, 3'd2, 1'b0);
        cyc(8'h00, 3'd2, 1'b0);
        settle();
        chk("t1_req", 32'(int_req), 32'd1);
        chk("t1_id", 32'(int_id), 32'd3);
        chk("t1_prio", 32'(int_prio), 32'd4);
        chk("t1_vector", 32'(int_vector), 32'h0180);
        cyc(8'h00, 3'd2, 1'b0);
        settle();
        chk("t1_pending_held", 32'(pending[3]), 32'd1);
        cyc(8'h00, 3'd2, 1'b1);
        settle();
        chk("t1_req_after_ack", 32'(int_req), 32'd0);
        chk("t1_pending_after_ack", 32'(pending), 32'd0);

        // Priority tie resolves to the lower index, bubble, then the other channel.
        cfg(1, 1'b1, 3'd5, 8'h11);
        cfg(6, 1'b1, 3'd5, 8'h66);
        cyc(8'h42, 3'd0, 1'b0);
        cyc(8'h00, 3'd0, 1'b0);
        settle();
        chk("t2_id_tie", 32'(int_id), 32'd1);
        chk("t2_vec_tie", 32'(int_vector), 32'h0111);
        cyc(8'h00, 3'd0, 1'b1);
        settle();
        chk("t2_bubble", 32'(int_req), 32'd0);
        cyc(8'h00, 3'd0, 1'b0);
        settle();
        chk("t2_req_next", 32'(int_req), 32'd1);
        chk("t2_id_next", 32'(int_id), 32'd6);
        chk("t2_vec_next", 32'(int_vector), 32'h0166);
        cyc(8'h00, 3'd0, 1'b1);
        cyc(8'h00, 3'd0, 1'b0);

        // Strict compare against cur_prio; raising cur_prio drops the request only.
        cfg(2, 1'b1, 3'd3, 8'h22);
        cyc(8'h04, 3'd3, 1'b0);
        cyc(8'h00, 3'd3, 1'b0);
        settle();
        chk("t3_equal_prio", 32'(int_req), 32'd0);
        cyc(8'h00, 3'd2, 1'b0);
        settle();
        chk("t3_lower_cur", 32'(int_req), 32'd1);
        chk("t3_id", 32'(int_id), 32'd2);
        cyc(8'h00, 3'd7, 1'b0);
        settle();
        chk("t3_raised_cur", 32'(int_req), 32'd0);
        chk("t3_pending_kept", 32'(pending[2]), 32'd1);
        cyc(8'h00, 3'd2, 1'b0);
        cyc(8'h00, 3'd2, 1'b1);
        cyc(8'h00, 3'd2, 1'b0);

        // Level channel 0 survives an ack while its line stays high.
        cfg(0, 1'b1, 3'd6, 8'h30);
        cyc(8'h01, 3'd0, 1'b0);
        cyc(8'h01, 3'd0, 1'b0);
        settle();
        chk("t4_req", 32'(int_req), 32'd1);
        chk("t4_id", 32'(int_id), 32'd0);
        cyc(8'h01, 3'd0, 1'b1);
        settle();
        chk("t4_bubble", 32'(int_req), 32'd0);
        cyc(8'h01, 3'd0, 1'b0);
        settle();
        chk("t4_req_again", 32'(int_req), 32'd1);
        cyc(8'h00, 3'd0, 1'b0);
        settle();
        chk("t4_level_drop", 32'(pending[0]), 32'd0);
        cyc(8'h00, 3'd0, 1'b0);

        // Disabled channel keeps capturing; enable releases it; set beats clear.
        cfg(5, 1'b0, 3'd5, 8'h55);
        cyc(8'h20, 3'd0, 1'b0);
        cyc(8'h00, 3'd0, 1'b0);
        settle();
        chk("t5_disabled_req", 32'(int_req), 32'd0);
        chk("t5_disabled_pend", 32'(pending[5]), 32'd1);
        cfg(5, 1'b1, 3'd5, 8'h55);
        cyc(8'h00, 3'd0, 1'b0);
        settle();
        chk("t5_enabled_req", 32'(int_req), 32'd1);
        chk("t5_enabled_vec", 32'(int_vector), 32'h0155);
        cyc(8'h20, 3'd0, 1'b1);
        settle();
        chk("t5_set_wins", 32'(pending[5]), 32'd1);
        chk("t5_ack_bubble", 32'(int_req), 32'd0);
        cyc(8'h20, 3'd0, 1'b0);
        settle();
        chk("t5_req_back", 32'(int_req), 32'd1);

        // Asynchronous reset during an active request and a config write.
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b1; cfg_sel = 3'd3; cfg_en = 1'b1; cfg_prio = 3'd7; cfg_vec = 8'hAA;
        #1;
        chk("t6_async_req", 32'(int_req), 32'd0);
        chk("t6_async_vec", 32'(int_vector), 32'd0);
        chk("t6_async_pend", 32'(pending), 32'd0);
        @(negedge clk);
        cfg_we = 1'b0; irq = 8'h00; rst = 1'b1;
        cyc(8'h28, 3'd0, 1'b0);
        cyc(8'h00, 3'd0, 1'b0);
        cyc(8'h00, 3'd0, 1'b0);
        settle();
        chk("t6_no_irq_unconfig", 32'(int_req), 32'd0);
        chk("t6_pend_captured", 32'(pending), 32'h28);

        // Random traffic checked by the scoreboard.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = (n == 1500) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 2) == 0)
                irq = irq ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0)
                cur_prio = 3'($urandom_range(0, 7));
            int_ack = ($urandom_range(0, 2) == 0);
            cfg_we  = ($urandom_range(0, 9) == 0);
            cfg_sel  = 3'($urandom_range(0, 7));
            cfg_en   = ($urandom_range(0, 3) != 0);
            cfg_prio = 3'($urandom_range(0, 7));
            cfg_vec  = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        cfg_we = 1'b0; int_ack = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_int_ctrl.md
Name: lc3_int_ctrl

Overview:
- Parametrised multi-channel interrupt controller for the LC-3 datapath. It replaces the single IRQ/INTP/INTV latch with NUM_CH independently configurable request channels.
- Each channel has a pending latch, an edge or level capture mode, an enable bit, a priority and a vector.
- It resolves the winning request against the current PSR priority and presents a registered request, vector and channel ID to control. The control FSM acknowledges the interrupt when it enters the service sequence.

Parameters:
- NUM_CH, 8, number of interrupt channels (2..16)
- PRIO_W, 3, priority field width; matches PSR[10:8]
- VEC_W, 8, per-channel vector width
- VEC_BASE, 8'h01, upper byte of the interrupt vector table address
- EDGE_MASK, {NUM_CH{1'b1}}, bit i=1: channel i is edge-captured; bit i=0: level-sensitive

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0, released synchronously to clk by the top level)
- irq  in  NUM_CH  per-channel request lines, synchronous to clk
- cur_prio  in  PRIO_W  current processor priority (PSR[10:8])
- cfg_we  in  1  configuration write strobe
- cfg_sel  in  $clog2(NUM_CH)  channel addressed by a config write
- cfg_en  in  1  enable value to write
- cfg_prio  in  PRIO_W  priority value to write
- cfg_vec  in  VEC_W  vector value to write
- int_ack  in  1  control accepts the presented interrupt
- int_req  out  1  registered; a qualified interrupt is pending
- int_id  out  $clog2(NUM_CH)  registered; winning channel index
- int_prio  out  PRIO_W  registered; winning channel priority (loaded into PSR by control)
- int_vector  out  16  registered; {VEC_BASE, vec[int_id]}
- pending  out  NUM_CH  raw pending latches, for debug/status reads

Behaviour:
- Reset (rst=0, asynchronous):
  - pending, en, prio, vec, irq_d and all outputs go to 0; int_vector=16'h0000.
  - A reset asserted mid-handshake discards all pending and configuration state.
- Edge capture (EDGE_MASK[i]=1):
  - irq_d[i] is registered every cycle.
  - pending[i] sets on irq[i]=1 with irq_d[i]=0.
  - pending[i] clears only by an accepted ack with int_id=i.
  - If a new edge and a clearing ack on the same channel occur in one cycle, set wins and pending stays 1.
- Level capture (EDGE_MASK[i]=0):
  - pending[i] = irq[i], registered each cycle.
  - Ack has no effect; the source must drop its line.
- Enable:
  - en[i]=0 excludes channel i from arbitration.
  - Pending capture continues while disabled, so a pending edge is serviced once the channel is re-enabled.
- Configuration:
  - cfg_we=1 writes en/prio/vec of channel cfg_sel at the clock edge.
  - The new values take part in arbitration from the next cycle.
  - A write to cfg_sel >= NUM_CH is ignored.
- Arbitration (combinational, registered at the output):
  - Candidates are channels with pending[i]&en[i].
  - Winner = highest prio; ties go to the lowest index.
  - qualify = any candidate AND winner prio > cur_prio (strict).
  - A channel with prio=0 can never interrupt.
- Output register:
  - Each cycle: int_req<=qualify; int_id/int_prio/int_vector <= winner fields.
  - When qualify=0: int_id, int_prio and int_vector hold their previous values.
  - Latency from irq edge to int_req=1 is 2 cycles: pending capture, then output register.
  - Outputs re-evaluate every cycle, so a higher-priority arrival can replace int_id before ack.
- Ack handshake:
  - Accepted only when int_ack=1 AND int_req=1; an ack with int_req=0 is ignored.
  - The channel cleared is the one in the int_id register at that edge, not a newly computed winner.
  - Cycle after ack: int_req is forced to 0 for one cycle (bubble). This lets control update cur_prio before re-arbitration.
  - Back-to-back acks cannot double-clear a channel.
- cur_prio change: takes effect in the next registered int_req. A raised cur_prio drops int_req without touching pending.
- Width rules:
  - int_vector is VEC_BASE concatenated with vec, zero-extended if VEC_W < 8.
  - VEC_W > 8 is illegal; elaboration must assert this.

Test Plan:
- Reset then config ch3 {en=1, prio=4, vec=8'h80}; cur_prio=2; pulse irq[3] for 1 cycle -> int_req=1 two cycles later, int_id=3, int_prio=4, int_vector=16'h0180; pending[3]=1 until ack; after ack, int_req=0 and pending=0.
- Ch1 prio=5 and ch6 prio=5 both pending, cur_prio=0 -> int_id=1. Ack -> bubble cycle, then int_id=6, int_vector={8'h01, vec[6]}.
- Ch2 prio=3 pending, cur_prio=3 -> int_req stays 0. Lower cur_prio to 2 -> int_req=1 next cycle. Raise cur_prio to 7 before ack -> int_req=0, pending[2] remains 1.
- Level channel 0 (EDGE_MASK[0]=0), prio=6, held high through ack -> int_req returns to 1 after the bubble. Drop irq[0] -> pending[0]=0 next cycle.
- Ch5 disabled, edge arrives -> pending[5]=1, int_req=0. Enable via cfg write -> int_req=1 two cycles after the write. Ack coinciding with a new irq[5] edge -> pending[5] stays 1.
- Assert rst=0 while int_req=1 and cfg_we active -> all outputs 0 immediately (asynchronous). After release, no interrupt until reconfiguration.
